// File: rtl/adc_avg_pkg.sv
// Shared width helpers for the multi-channel ADC window averager.
package adc_avg_pkg;

  // Channel index width; a single channel still needs a one-bit index.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Running-sum width: one full window of maximum samples cannot overflow it.
  function automatic int sum_width(input int sample_width, input int log2_depth);
    return sample_width + log2_depth;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one synchronous read port, one write port.
module sample_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Registered read and write; contents are never reset so this maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_window_averager.sv
// Multi-channel moving-average filter: per-channel circular window with running sum.
module adc_window_averager
  import adc_avg_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LOG2_DEPTH   = 8,
  parameter int CHANNELS     = 2,
  parameter int FILL_MODE    = 0,
  localparam int CH_W        = ch_width(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    hold,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  output logic                    ave_valid,
  output logic [CH_W-1:0]         ave_ch,
  output logic [SAMPLE_WIDTH-1:0] ave_out,
  output logic [CHANNELS-1:0]     ave_full
);

  localparam int SUM_W  = sum_width(SAMPLE_WIDTH, LOG2_DEPTH);
  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int FILL_W = LOG2_DEPTH + 1;
  localparam int ADDR_W = CH_W + LOG2_DEPTH;

  // Field widths follow the instance parameters, so the stage record lives here.
  typedef struct packed {
    logic                    valid;
    logic [CH_W-1:0]         ch;
    logic [ADDR_W-1:0]       addr;
    logic [SAMPLE_WIDTH-1:0] data;
  } pipe_t;

  logic [LOG2_DEPTH-1:0] wp   [CHANNELS];
  logic [FILL_W-1:0]     fill [CHANNELS];
  logic [SUM_W-1:0]      sum  [CHANNELS];

  pipe_t                   s1, s2;
  logic                    in_range, accept, kill;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic [SUM_W-1:0]        old_val, new_sum;
  logic                    was_full, now_full, emit;

  generate
    if (CHANNELS == (1 << CH_W)) begin : g_all_in_range
      assign in_range = 1'b1;
    end else begin : g_range_check
      assign in_range = ({{(32-CH_W){1'b0}}, in_ch} < 32'(CHANNELS));
    end
  endgenerate

  assign kill   = !reset_n || clear;
  assign accept = in_valid && in_range && !kill;

  // Stage 1: the incoming sample and the window slot it will replace.
  always_comb begin
    s1       = '0;
    s1.valid = accept;
    s1.ch    = in_ch;
    s1.addr  = {in_ch, wp[in_ch]};
    s1.data  = in_data;
  end

  // Stage 2 arithmetic: slots never written since clear contribute zero.
  always_comb begin
    was_full = (fill[s2.ch] == FILL_W'(DEPTH));
    now_full = was_full || (fill[s2.ch] == FILL_W'(DEPTH - 1));
    old_val  = was_full ? SUM_W'(rd_data) : '0;
    new_sum  = sum[s2.ch] - old_val + SUM_W'(s2.data);
    emit     = s2.valid && !hold && ((FILL_MODE == 0) || now_full);
  end

  sample_ram #(
    .DATA_W (SAMPLE_WIDTH),
    .ADDR_W (ADDR_W),
    .DEPTH  (CHANNELS * DEPTH)
  ) u_ram (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (s1.addr),
    .rd_data (rd_data),
    .wr_en   (s2.valid && !kill),
    .wr_addr (s2.addr),
    .wr_data (s2.data)
  );

  // Write pointers advance in stage 1 so back-to-back samples hit fresh slots.
  always_ff @(posedge clk) begin
    if (kill) begin
      for (int c = 0; c < CHANNELS; c++) wp[c] <= '0;
    end else if (accept) begin
      wp[in_ch] <= wp[in_ch] + LOG2_DEPTH'(1);
    end
  end

  // Stage register between the RAM read and the sum update.
  always_ff @(posedge clk) begin
    if (kill) s2 <= '0;
    else      s2 <= s1;
  end

  // Running sums and saturating fill counters, updated in stage 2.
  always_ff @(posedge clk) begin
    if (kill) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c]  <= '0;
        fill[c] <= '0;
      end
    end else if (s2.valid) begin
      sum[s2.ch] <= new_sum;
      if (!was_full) fill[s2.ch] <= fill[s2.ch] + FILL_W'(1);
    end
  end

  // Output register: only refreshed when a pulse is emitted, so hold freezes it.
  always_ff @(posedge clk) begin
    if (kill) begin
      ave_valid <= 1'b0;
      ave_ch    <= '0;
      ave_out   <= '0;
    end else begin
      ave_valid <= emit;
      if (emit) begin
        ave_out <= new_sum[SUM_W-1:LOG2_DEPTH];
        ave_ch  <= s2.ch;
      end
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_full
      assign ave_full[c] = (fill[c] == FILL_W'(DEPTH));
    end
  endgenerate

endmodule
